// File: rtl/fifo_tx_serializer_if.sv
// FIFO read-side bundle between fifo_tx_serializer (master) and an upstream
// synchronous FIFO (slave).
interface fifo_tx_serializer_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read_en
  );
endinterface

// File: rtl/fifo_tx_serializer.sv
// Pops bytes from a synchronous FIFO and sends them as 8N1 serial frames.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module fifo_tx_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tx_en,
  fifo_tx_serializer_if.master        fifo,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

`ifdef FIFO_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  state_t      state_r, state_next_s;
  logic [7:0]  cnt_r, cnt_next_s;
  logic [2:0]  idx_r, idx_next_s;
  logic [7:0]  sh_r, sh_next_s;
  logic        tx_r, tx_next_s;
  logic        read_en_r;
  logic        busy_r;
  logic        done_r;
  logic        bit_end_s;
`ifdef FIFO_TX_PARITY_EN
  logic        par_r, par_next_s;
`endif

  assign bit_end_s         = (cnt_r == 8'd0);
  assign fifo.fifo_read_en = read_en_r;
  assign tx                = tx_r;
  assign busy              = busy_r;
  assign frame_done        = done_r;

  // Next-state, bit timing, shift register and the next serial line level
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    idx_next_s   = idx_r;
    sh_next_s    = sh_r;
    tx_next_s    = tx_r;
`ifdef FIFO_TX_PARITY_EN
    par_next_s   = par_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_next_s = 8'd0;
        idx_next_s = 3'd0;
        tx_next_s  = 1'b1;
        if (tx_en && !fifo.fifo_empty) begin
          state_next_s = POP;
        end else begin
          state_next_s = IDLE;
        end
      end
      POP: begin
        state_next_s = WAIT;
        tx_next_s    = 1'b1;
      end
      WAIT: begin
        // FIFO read data is valid now, one cycle after the pop
        state_next_s = START;
        sh_next_s    = fifo.fifo_data;
        cnt_next_s   = CNT_LAST;
        tx_next_s    = 1'b0;
`ifdef FIFO_TX_PARITY_EN
        par_next_s   = even_parity(fifo.fifo_data);
`endif
      end
      START: begin
        if (bit_end_s) begin
          state_next_s = DATA;
          cnt_next_s   = CNT_LAST;
          idx_next_s   = 3'd0;
          tx_next_s    = sh_r[0];
        end else begin
          cnt_next_s   = cnt_r - 8'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_next_s = CNT_LAST;
          if (idx_r == 3'd7) begin
`ifdef FIFO_TX_PARITY_EN
            state_next_s = PARITY;
            tx_next_s    = par_r;
`else
            state_next_s = STOP;
            tx_next_s    = 1'b1;
`endif
          end else begin
            idx_next_s = idx_r + 3'd1;
            sh_next_s  = {1'b0, sh_r[7:1]};
            tx_next_s  = sh_r[1];
          end
        end else begin
          cnt_next_s = cnt_r - 8'd1;
        end
      end
`ifdef FIFO_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_next_s = STOP;
          cnt_next_s   = CNT_LAST;
          tx_next_s    = 1'b1;
        end else begin
          cnt_next_s   = cnt_r - 8'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          state_next_s = IDLE;
          cnt_next_s   = 8'd0;
          tx_next_s    = 1'b1;
        end else begin
          cnt_next_s   = cnt_r - 8'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 8'd0;
        tx_next_s    = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs; reset drops any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      idx_r     <= 3'd0;
      sh_r      <= 8'd0;
      tx_r      <= 1'b1;
      read_en_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      idx_r     <= idx_next_s;
      sh_r      <= sh_next_s;
      tx_r      <= tx_next_s;
      read_en_r <= (state_next_s == POP);
      busy_r    <= (state_next_s != IDLE);
      // cnt_r == 1 in STOP means the coming cycle is the last of the stop bit
      done_r    <= (state_r == STOP) && (cnt_r == 8'd1);
`ifdef FIFO_TX_PARITY_EN
      par_r     <= par_next_s;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Scoreboard bench for fifo_tx_serializer: stimulus queues expected bytes,
// a negedge monitor decodes every frame on tx and compares.
`timescale 1ns/1ps
module tb_fifo_tx_serializer;
  localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic reset;
  logic tx_en;
  logic tx, busy, frame_done;

  fifo_tx_serializer_if bus();

  fifo_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo(bus),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Upstream synchronous FIFO model with registered read data
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_read_en === 1'b1) begin
      bus.fifo_data <= mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int mon_pos = -1;
  int busy_low_cnt = 0;
  logic [7:0] cur_b = 8'h00;
  bit frame_ok = 1'b1;
  int pop_cyc[$], start_cyc[$], end_cyc[$], blc_pop[$], blc_end[$];

  function automatic logic exp_bit(input logic [7:0] b, input int n);
    logic r;
    if (n == 0) r = 1'b0;
    else if (n <= 8) r = b[n-1];
`ifdef FIFO_TX_PARITY_EN
    else if (n == 9) r = ^b;
`endif
    else r = 1'b1;
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset !== 1'b0) begin
        mon_pos = -1;
      end else begin
        if (bus.fifo_read_en === 1'b1) begin
          pop_cyc.push_back(cyc);
          blc_pop.push_back(busy_low_cnt);
          if (bus.fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL pop_while_empty: fifo_read_en=1 with fifo_empty=%b, need no pop", bus.fifo_empty);
          end
        end
        if (busy === 1'b0) busy_low_cnt++;
        if (mon_pos < 0) begin
          if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL stray_frame_done: frame_done=%b outside a frame, need 0", frame_done);
          end
          if (tx === 1'b0) begin
            mon_pos  = 0;
            frame_ok = 1'b1;
            start_cyc.push_back(cyc);
            checks++;
            if (pop_cyc.size() == 0) begin
              errors++;
              $display("FAIL pop_to_start: start bit with no preceding pop, need pop 2 cycles before");
            end else if (cyc - pop_cyc[pop_cyc.size()-1] != 2) begin
              errors++;
              $display("FAIL pop_to_start: %0d cycles, need 2", cyc - pop_cyc[pop_cyc.size()-1]);
            end
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              cur_b = 8'h00;
              $display("FAIL unexpected_frame: frame started with empty scoreboard, need none");
            end else begin
              cur_b = exp_q.pop_front();
            end
          end
        end
        if (mon_pos >= 0) begin
          logic eb, ed;
          eb = exp_bit(cur_b, mon_pos / CPB);
          ed = (mon_pos == FRAME - 1);
          if (tx !== eb || busy !== 1'b1 || frame_done !== ed) begin
            if (frame_ok)
              $display("FAIL frame_bits byte=%h pos=%0d: tx=%b busy=%b frame_done=%b, need tx=%b busy=1 frame_done=%b",
                       cur_b, mon_pos, tx, busy, frame_done, eb, ed);
            frame_ok = 1'b0;
          end
          if (ed) begin
            checks++;
            if (!frame_ok) errors++;
            end_cyc.push_back(cyc);
            blc_end.push_back(busy_low_cnt);
            mon_pos = -1;
          end else begin
            mon_pos++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    exp_q.push_back(b);
    wr_ptr++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ends(input int n);
    int budget = 0;
    while (end_cyc.size() < n && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    #2;
    check("wait_frame_end", end_cyc.size() >= n, 1);
  endtask

  task automatic wait_starts(input int n);
    int budget = 0;
    while (start_cyc.size() < n && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    #2;
    check("wait_frame_start", start_cyc.size() >= n, 1);
  endtask

  initial begin
    int bad;
    int npops;
    reset = 1'b1;
    tx_en = 1'b0;
    tick(3);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_read_en", bus.fifo_read_en, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    tx_en = 1'b1;

    // Empty FIFO with tx_en held: nothing may happen
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_read_en !== 1'b0) bad++;
    end
    check("empty_bad_cycles", bad, 0);
    check("empty_no_pop", pop_cyc.size(), 0);

    push(8'hA5);
    wait_ends(1);
    check("a5_single_pop", pop_cyc.size(), 1);

    // Back-to-back frames
    push(8'h3C);
    push(8'hC3);
    wait_ends(3);
    check("b2b_pop_spacing", pop_cyc[2] - pop_cyc[1], FRAME + 3);
    check("b2b_gap", start_cyc[2] - end_cyc[1], 4);
    check("b2b_busy_low", blc_end[2] - blc_pop[1], 1);

    // Reset during data bit 3; byte is lost
    push(8'hF0);
    wait_starts(4);
    tick(17);
    reset = 1'b1;
    tick(1);
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    reset = 1'b0;
    tick(FRAME + 10);
    check("midrst_no_end", end_cyc.size(), 3);
    push(8'h55);
    wait_ends(4);

    // tx_en dropped during START
    push(8'h96);
    push(8'h01);
    wait_starts(6);
    tx_en = 1'b0;
    npops = pop_cyc.size();
    wait_ends(5);
    tick(20);
    check("txen_no_pop", pop_cyc.size(), npops);
    check("txen_byte_held", exp_q.size(), 1);
    tx_en = 1'b1;
    wait_ends(6);
    check("txen_resume_pop", pop_cyc.size(), npops + 1);
    check("scoreboard_empty", exp_q.size(), 0);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_tx_serializer.md
FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 2..255.
REQ-002 The block SHALL have port clk, input, width 1: single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset, input, width 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port tx_en, input, width 1: permits starting a new frame.
REQ-005 The block SHALL have port fifo_empty, input, width 1: empty flag of the upstream synchronous FIFO.
REQ-006 The block SHALL have port fifo_data, input, width 8: registered FIFO read data, valid the cycle after a pop.
REQ-007 The block SHALL have port fifo_read_en, output, width 1: pop strobe to the FIFO.
REQ-008 The block SHALL have port tx, output, width 1: serial line, idle high.
REQ-009 The block SHALL have port busy, output, width 1: high in every state except IDLE.
REQ-010 The block SHALL have port frame_done, output, width 1: one-cycle pulse when a stop bit completes.

Function
REQ-011 The FSM SHALL have states IDLE, POP, WAIT, START, DATA, PARITY (macro-dependent) and STOP.
REQ-012 IDLE to POP SHALL occur at edge k when tx_en=1 and fifo_empty=0; otherwise the FSM stays in IDLE.
REQ-013 fifo_read_en SHALL be high only while in POP, for exactly one cycle per frame, and never while fifo_empty=1.
REQ-014 POP SHALL be followed unconditionally by WAIT, and fifo_data SHALL be captured into an 8-bit shift register on the edge leaving WAIT.
REQ-015 tx SHALL first drive 0 (start bit) in cycle k+3, i.e. three edges after the qualifying IDLE sample.
REQ-016 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads at every bit boundary.
REQ-017 DATA SHALL send 8 bits LSB first, tracked by a 3-bit bit index, and exit after index 7.
REQ-018 STOP SHALL drive tx=1, and on its final cycle frame_done SHALL be 1 and the next state SHALL be IDLE.
REQ-019 tx SHALL be a registered output held at 1 in IDLE, POP and WAIT.
REQ-020 tx_en deasserting mid-frame SHALL NOT abort the frame; it only blocks the next IDLE to POP transition.
REQ-021 Back-to-back frames SHALL have a minimum gap of 3 cycles of tx=1 (IDLE, POP, WAIT) after STOP.
REQ-022 fifo_empty and fifo_data SHALL be ignored outside IDLE and WAIT, respectively.

Reset
REQ-023 While reset=1 at a clock edge, the block SHALL set state to IDLE, tx=1, fifo_read_en=0, busy=0, frame_done=0, and clear the counters and shift register.
REQ-024 Reset asserted mid-frame SHALL abandon the frame immediately, with no stop bit and no frame_done, and the popped byte SHALL be lost.

Configuration
REQ-025 With macro FIFO_TX_PARITY_EN defined, the block SHALL insert a PARITY state between DATA and STOP that drives the XOR of the 8 data bits (even parity), giving a frame of 11 bit periods.
REQ-026 With FIFO_TX_PARITY_EN undefined, the block SHALL contain no PARITY state or logic, DATA SHALL go directly to STOP, and the frame SHALL be 10 bit periods.

Verification
REQ-027 CLKS_PER_BIT=4, no parity, FIFO holds 0xA5, tx_en=1 -> one pop; tx=0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frame_done pulses once on cycle 40 of the frame.
REQ-028 FIFO_TX_PARITY_EN defined, byte 0xA5 -> parity bit 0; byte 0x01 -> parity bit 1; frame spans 44 cycles.
REQ-029 FIFO holds 0x3C, 0xC3, tx_en held 1 -> two pops exactly 43 cycles apart, 3 idle-high cycles between frames, busy=0 only in the gap cycles.
REQ-030 fifo_empty=1, tx_en=1 for 100 cycles -> fifo_read_en stays 0, tx stays 1, busy stays 0.
REQ-031 reset=1 for one cycle during DATA bit 3 -> next cycle tx=1, busy=0, no frame_done; a following byte 0x55 transmits correctly.
REQ-032 tx_en dropped during START -> frame completes normally, and no further pop occurs while tx_en=0.
